uart_stream_fifo: RTL and testbench
===================================

Name: uart_stream_fifo

Overview:
Parametrised byte buffer between a uart_rx store-pulse interface and a uart_tx toggle load-request interface. Successor to the fixed 4-entry loopback buffer. Adds:
- configurable data width and depth
- occupancy and full/empty flags
- overflow policy (drop-newest / overwrite-oldest)
- errored-byte filtering with an error counter
- synchronous flush
Sits in the uart top between u_rx and u_tx, all on one clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored character (5..9)
DEPTH_LOG2, 2, log2 of FIFO depth; depth = 2**DEPTH_LOG2 (1..8)
OVERWRITE, 0, 0 = drop incoming byte when full; 1 = discard oldest entry and accept incoming byte
DROP_ERRORS, 1, 1 = bytes flagged with i_error are not stored; 0 = stored normally
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
i_clock  in  1  single clock for the whole block
i_reset  in  1  synchronous, active-low reset (sampled on posedge i_clock)
i_store_req  in  1  one-cycle pulse from uart_rx: i_data valid this cycle
i_data  in  DATA_WIDTH  received character
i_error  in  1  parity or stop-bit error for this character, qualified by i_store_req
i_load_req  in  1  toggle from uart_tx; differs from o_load_ack when tx wants a character
o_load_ack  out  1  toggle acknowledge to uart_tx
o_data  out  DATA_WIDTH  character presented to uart_tx, held between loads
i_flush  in  1  synchronous flush of FIFO contents
i_clear  in  1  clears o_overflow and o_error_count
o_count  out  DEPTH_LOG2+1  current occupancy 0..depth
o_empty  out  1  o_count == 0
o_full  out  1  o_count == depth
o_overflow  out  1  sticky: a byte was lost or overwritten
o_error_count  out  ERR_CNT_WIDTH  saturating count of store pulses with i_error high

Behaviour:
- Reset (i_reset == 0 at posedge): pointers, o_count, o_load_ack, o_data, o_overflow, o_error_count all 0. o_empty = 1, o_full = 0. Reset overrides every other input.
- Pointers: DEPTH_LOG2-bit write and read pointers with natural wrap. o_count is a separate register; o_empty and o_full are decoded from o_count.
- need_load = (i_load_req != o_load_ack). Pop occurs when need_load and o_count != 0. On pop:
  - o_data <= mem[rd]
  - rd <= rd+1
  - o_load_ack <= i_load_req
- No fall-through. A byte pushed in cycle N is poppable at the earliest in N+1, so o_data changes at the end of N+1.
- Push is requested when i_store_req && !(i_error && DROP_ERRORS).
  - Not full: mem[wr] <= i_data, wr++.
  - Full and a pop in the same cycle: push accepted, o_count unchanged.
  - Full, no pop, OVERWRITE=0: byte dropped, o_overflow <= 1.
  - Full, no pop, OVERWRITE=1: mem[wr] <= i_data, wr++, rd++ (oldest lost), o_count stays at depth, o_overflow <= 1.
- o_count update: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds depth or goes below 0.
- Error counter: increments on i_store_req && i_error, saturates at all-ones. It counts regardless of DROP_ERRORS.
- i_flush: wr <= 0, rd <= 0, o_count <= 0. It takes priority over a same-cycle push and pop: the pushed byte is discarded and no load occurs. o_data and o_load_ack are unchanged, so a pending tx request stays pending.
- i_clear: o_overflow <= 0 and o_error_count <= 0. A same-cycle overflow or error event wins, leaving overflow = 1 or count = 1.
- Empty and need_load: nothing happens; the request stays pending until a byte arrives.

Decomposition:
- Shared package: depth/width helper constants (DEPTH = 1 << DEPTH_LOG2) and overflow-policy constants (POLICY_DROP = 0, POLICY_OVERWRITE = 1).
- One natural sub-module: fifo_mem_sync, a parametrised single-clock register array with write port and asynchronous read at rd. Pointer, count and handshake logic stay in uart_stream_fifo.

Test Plan:
1. Reset with i_reset=0 for 2 cycles while i_store_req pulses -> o_count=0, o_empty=1, o_load_ack=0, o_data=0, o_error_count=0.
2. Defaults, tx idle (i_load_req == o_load_ack): push 0x11,0x22,0x33,0x44 -> o_full=1, o_count=4. Toggle i_load_req four times, waiting for each ack -> o_data sequence 0x11,0x22,0x33,0x44, then o_empty=1.
3. OVERWRITE=0, FIFO full with 0xA0..0xA3: push 0xFF -> o_overflow=1, o_count=4, drained order 0xA0..0xA3. Repeat with OVERWRITE=1 -> drained order 0xA1,0xA2,0xA3,0xFF.
4. Full FIFO, pending load and i_store_req in the same cycle -> o_count stays 4, o_overflow stays 0, the new byte is drained last.
5. Push 0x55 with i_error=1, DROP_ERRORS=1 -> o_count unchanged, o_error_count=1. 300 errored pulses with ERR_CNT_WIDTH=8 -> counter holds 255.
6. Push 3 bytes, assert i_flush in the same cycle as a push and a pending load -> o_count=0, o_load_ack unchanged. A later push of 0x7E is loaded as o_data=0x7E with o_load_ack toggled.

Source files
------------

// File: rtl/uart_stream_fifo_pkg.sv
// Shared constants for the uart_stream_fifo buffer.
// Covers the depth helper and the overflow-policy encodings.
package uart_stream_fifo_pkg;

    localparam int unsigned POLICY_DROP      = 0;
    localparam int unsigned POLICY_OVERWRITE = 1;

    function automatic int unsigned fifo_depth(input int unsigned depth_log2);
        return 32'd1 << depth_log2;
    endfunction

endpackage

// File: rtl/fifo_mem_sync.sv
// Single-clock register array for uart_stream_fifo.
// It has one write port and an asynchronous read port.
module fifo_mem_sync #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  i_clock,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_stream_fifo.sv
// Byte buffer between the uart_rx store pulse and the uart_tx toggle load handshake.
// Provides occupancy flags, an overflow policy, errored-byte filtering and a flush.
module uart_stream_fifo
    import uart_stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH_LOG2    = 2,
    parameter int unsigned OVERWRITE     = POLICY_DROP,
    parameter int unsigned DROP_ERRORS   = 1,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_store_req,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_error,
    input  logic                     i_load_req,
    output logic                     o_load_ack,
    output logic [DATA_WIDTH-1:0]    o_data,
    input  logic                     i_flush,
    input  logic                     i_clear,
    output logic [DEPTH_LOG2:0]      o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic [ERR_CNT_WIDTH-1:0] o_error_count
);

    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(fifo_depth(DEPTH_LOG2));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);
    localparam bit OVERWRITE_EN = (OVERWRITE == POLICY_OVERWRITE);
    localparam bit DROP_EN = (DROP_ERRORS != 0);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  need_load;
    logic                  pop;
    logic                  push_req;
    logic                  full_block;
    logic                  push;
    logic                  overwrite;
    logic                  error_evt;

    // Flush is folded into pop/push so one gate covers the pointers, memory and handshake.
    always_comb begin
        need_load  = (i_load_req != o_load_ack);
        pop        = need_load && (o_count != '0) && !i_flush;
        push_req   = i_store_req && !(i_error && DROP_EN) && !i_flush;
        full_block = push_req && o_full && !pop;
        push       = push_req && (!full_block || OVERWRITE_EN);
        overwrite  = full_block && OVERWRITE_EN;
        error_evt  = i_store_req && i_error;
    end

    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == DEPTH);

    fifo_mem_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .i_clock   (i_clock),
        .i_wr_en   (push),
        .i_wr_addr (wr_ptr),
        .i_wr_data (i_data),
        .i_rd_addr (rd_ptr),
        .o_rd_data (rd_data)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_count       <= '0;
            o_load_ack    <= 1'b0;
            o_data        <= '0;
            o_overflow    <= 1'b0;
            o_error_count <= '0;
        end else begin
            if (i_flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                o_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop || overwrite) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (push && !pop && !overwrite) begin
                    o_count <= o_count + CNT_ONE;
                end else if (pop && !push) begin
                    o_count <= o_count - CNT_ONE;
                end
                if (pop) begin
                    o_data     <= rd_data;
                    o_load_ack <= i_load_req;
                end
            end

            // A same-cycle event beats i_clear on both sticky status registers.
            if (full_block) begin
                o_overflow <= 1'b1;
            end else if (i_clear) begin
                o_overflow <= 1'b0;
            end

            if (error_evt) begin
                if (i_clear) begin
                    o_error_count <= ERR_ONE;
                end else if (o_error_count != '1) begin
                    o_error_count <= o_error_count + ERR_ONE;
                end
            end else if (i_clear) begin
                o_error_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_stream_fifo.sv
// Self-checking bench for uart_stream_fifo: drop and overwrite variants share stimulus.
// A vector table covers the directed cases, and queue models check the random traffic.
module tb_uart_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n, st, err, ld, fl, clr;
    logic [7:0] din;

    logic       ack0, ack1, empty0, empty1, full0, full1, ovf0, ovf1;
    logic [7:0] dout0, dout1, ec0, ec1;
    logic [2:0] cnt0, cnt1;

    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    uart_stream_fifo #(
        .DATA_WIDTH(8), .DEPTH_LOG2(2), .OVERWRITE(0), .DROP_ERRORS(1), .ERR_CNT_WIDTH(8)
    ) dut0 (
        .i_clock(clk), .i_reset(rst_n), .i_store_req(st), .i_data(din), .i_error(err),
        .i_load_req(ld), .o_load_ack(ack0), .o_data(dout0), .i_flush(fl), .i_clear(clr),
        .o_count(cnt0), .o_empty(empty0), .o_full(full0), .o_overflow(ovf0),
        .o_error_count(ec0)
    );

    uart_stream_fifo #(
        .DATA_WIDTH(8), .DEPTH_LOG2(2), .OVERWRITE(1), .DROP_ERRORS(1), .ERR_CNT_WIDTH(8)
    ) dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_store_req(st), .i_data(din), .i_error(err),
        .i_load_req(ld), .o_load_ack(ack1), .o_data(dout1), .i_flush(fl), .i_clear(clr),
        .o_count(cnt1), .o_empty(empty1), .o_full(full1), .o_overflow(ovf1),
        .o_error_count(ec1)
    );

    // Reference model: one queue per policy (index 0 = drop newest, 1 = overwrite oldest).
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  md[2];
    bit          mack[2];
    bit          movf[2];
    int unsigned mec[2];

    task automatic model_update();
        logic [7:0] q[$];
        bit need, pop, pushreq, ovf_evt;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) q = q0; else q = q1;
            if (!rst_n) begin
                q.delete();
                md[p] = 8'h00; mack[p] = 0; movf[p] = 0; mec[p] = 0;
            end else begin
                need    = (ld != mack[p]);
                pop     = need && (q.size() != 0);
                pushreq = st && !err;
                ovf_evt = 0;
                if (fl) begin
                    q.delete();
                end else begin
                    if (pop) begin
                        md[p] = q.pop_front();
                        mack[p] = ld;
                    end
                    if (pushreq) begin
                        if (q.size() < 4) begin
                            q.push_back(din);
                        end else begin
                            ovf_evt = 1;
                            if (p == 1) begin
                                q.delete(0);
                                q.push_back(din);
                            end
                        end
                    end
                end
                if (ovf_evt) movf[p] = 1;
                else if (clr) movf[p] = 0;
                if (st && err) mec[p] = clr ? 1 : ((mec[p] == 255) ? 255 : mec[p] + 1);
                else if (clr) mec[p] = 0;
            end
            if (p == 0) q0 = q; else q1 = q;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("m_cnt0", 32'(cnt0), q0.size());
        chk("m_cnt1", 32'(cnt1), q1.size());
        chk("m_empty0", 32'(empty0), 32'(q0.size() == 0));
        chk("m_full1", 32'(full1), 32'(q1.size() == 4));
        chk("m_ack0", 32'(ack0), 32'(mack[0]));
        chk("m_ack1", 32'(ack1), 32'(mack[1]));
        chk("m_data0", 32'(dout0), 32'(md[0]));
        chk("m_data1", 32'(dout1), 32'(md[1]));
        chk("m_ovf0", 32'(ovf0), 32'(movf[0]));
        chk("m_ovf1", 32'(ovf1), 32'(movf[1]));
        chk("m_ec0", 32'(ec0), mec[0]);
        chk("m_ec1", 32'(ec1), mec[1]);
    endtask

    typedef struct {
        bit          rst_n;
        bit          st;
        logic [7:0]  d;
        bit          err;
        bit          tog;
        bit          fl;
        bit          clr;
        int unsigned cnt;
        logic [7:0]  d0;
        logic [7:0]  d1;
        bit          ack;
        bit          ovf;
        int unsigned ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit r, bit s, logic [7:0] d, bit e, bit t, bit f, bit c,
                               int unsigned n, logic [7:0] d0, logic [7:0] d1,
                               bit a, bit o, int unsigned ec);
        vec_t x;
        x.rst_n = r; x.st = s; x.d = d; x.err = e; x.tog = t; x.fl = f; x.clr = c;
        x.cnt = n; x.d0 = d0; x.d1 = d1; x.ack = a; x.ovf = o; x.ec = ec;
        return x;
    endfunction

    initial begin
        rst_n = 0; st = 0; din = 0; err = 0; ld = 0; fl = 0; clr = 0;

        //                rst st data  er tg fl cl  cnt d0     d1     ack ovf ec
        vecs.push_back(v(0, 1, 8'h11, 0, 0, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'h11, 1, 0, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'h11, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'h22, 0, 0, 0, 0,  2, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'h33, 0, 0, 0, 0,  3, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'h44, 0, 0, 0, 0,  4, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  3, 8'h11, 8'h11, 1, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  2, 8'h22, 8'h22, 0, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  1, 8'h33, 8'h33, 1, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  0, 8'h44, 8'h44, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hA0, 0, 0, 0, 0,  1, 8'h44, 8'h44, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hA1, 0, 0, 0, 0,  2, 8'h44, 8'h44, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hA2, 0, 0, 0, 0,  3, 8'h44, 8'h44, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hA3, 0, 0, 0, 0,  4, 8'h44, 8'h44, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hFF, 0, 0, 0, 0,  4, 8'h44, 8'h44, 0, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  3, 8'hA0, 8'hA1, 1, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  2, 8'hA1, 8'hA2, 0, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  1, 8'hA2, 8'hA3, 1, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  0, 8'hA3, 8'hFF, 0, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 1,  0, 8'hA3, 8'hFF, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hB0, 0, 0, 0, 0,  1, 8'hA3, 8'hFF, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hB1, 0, 0, 0, 0,  2, 8'hA3, 8'hFF, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hB2, 0, 0, 0, 0,  3, 8'hA3, 8'hFF, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hB3, 0, 0, 0, 0,  4, 8'hA3, 8'hFF, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'hC5, 0, 1, 0, 0,  4, 8'hB0, 8'hB0, 1, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  3, 8'hB1, 8'hB1, 0, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  2, 8'hB2, 8'hB2, 1, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  1, 8'hB3, 8'hB3, 0, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 1, 0, 0,  0, 8'hC5, 8'hC5, 1, 0, 0));
        vecs.push_back(v(1, 1, 8'h55, 1, 0, 0, 0,  0, 8'hC5, 8'hC5, 1, 0, 1));
        vecs.push_back(v(1, 1, 8'h56, 1, 0, 0, 0,  0, 8'hC5, 8'hC5, 1, 0, 2));
        vecs.push_back(v(1, 1, 8'h57, 1, 0, 0, 1,  0, 8'hC5, 8'hC5, 1, 0, 1));
        vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 1,  0, 8'hC5, 8'hC5, 1, 0, 0));
        vecs.push_back(v(1, 1, 8'h01, 0, 0, 0, 0,  1, 8'hC5, 8'hC5, 1, 0, 0));
        vecs.push_back(v(1, 1, 8'h02, 0, 0, 0, 0,  2, 8'hC5, 8'hC5, 1, 0, 0));
        vecs.push_back(v(1, 1, 8'h03, 0, 0, 0, 0,  3, 8'hC5, 8'hC5, 1, 0, 0));
        vecs.push_back(v(1, 1, 8'h04, 0, 1, 1, 0,  0, 8'hC5, 8'hC5, 1, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 0,  0, 8'hC5, 8'hC5, 1, 0, 0));
        vecs.push_back(v(1, 1, 8'h7E, 0, 0, 0, 0,  1, 8'hC5, 8'hC5, 1, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 0, 0, 0,  0, 8'h7E, 8'h7E, 0, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; st = vecs[i].st; din = vecs[i].d; err = vecs[i].err;
            fl = vecs[i].fl; clr = vecs[i].clr;
            if (vecs[i].tog) ld = ~ld;
            tick();
            chk($sformatf("v%0d_cnt0", i), 32'(cnt0), vecs[i].cnt);
            chk($sformatf("v%0d_cnt1", i), 32'(cnt1), vecs[i].cnt);
            chk($sformatf("v%0d_empty", i), 32'(empty0), 32'(vecs[i].cnt == 0));
            chk($sformatf("v%0d_full", i), 32'(full1), 32'(vecs[i].cnt == 4));
            chk($sformatf("v%0d_data0", i), 32'(dout0), 32'(vecs[i].d0));
            chk($sformatf("v%0d_data1", i), 32'(dout1), 32'(vecs[i].d1));
            chk($sformatf("v%0d_ack0", i), 32'(ack0), 32'(vecs[i].ack));
            chk($sformatf("v%0d_ack1", i), 32'(ack1), 32'(vecs[i].ack));
            chk($sformatf("v%0d_ovf0", i), 32'(ovf0), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_ovf1", i), 32'(ovf1), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_ec0", i), 32'(ec0), vecs[i].ec);
        end

        // Error counter saturation: 300 errored pulses into an 8-bit counter.
        st = 1; err = 1; din = 8'h55; fl = 0; clr = 0;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_ec0", 32'(ec0), 32'd255);
        chk("sat_ec1", 32'(ec1), 32'd255);
        chk("sat_cnt0", 32'(cnt0), 32'd0);
        st = 0; err = 0; clr = 1;
        tick();
        chk("sat_clr_ec0", 32'(ec0), 32'd0);
        clr = 0;

        // Random traffic against the queue models; tx only toggles when idle.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            st    = ($urandom_range(0, 1) == 1);
            err   = ($urandom_range(0, 7) == 0);
            din   = 8'($urandom);
            fl    = ($urandom_range(0, 39) == 0);
            clr   = ($urandom_range(0, 29) == 0);
            if (ld == mack[0] && $urandom_range(0, 2) == 0) ld = ~ld;
            tick();
            chk_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
